// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the issue stage and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [1:0]       hi_we;
   logic [1:0]       lo_we;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, hi_we, lo_we, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, hi_we, lo_we, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers (34-cycle latency).
// Optional MULDIV_FAST_MULT_EN: single-cycle multiply, IDLE -> WRITE for MULT/MULTU.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   generate
      if (WIDTH != 32) begin : g_width_check
         $error("muldiv_unit supports WIDTH=32 only");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, FIX, WRITE} state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     counter_reg;
   logic                 is_div_reg;
   logic                 dbz_reg;
   logic                 neg_res_reg;
   logic                 neg_rem_reg;
   logic [WIDTH-1:0]     mag_a_reg, mag_b_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]     rem_reg, quo_reg;
   logic [WIDTH-1:0]     hi_reg, lo_reg;

   logic                 a_neg, b_neg;
   logic [2*WIDTH-1:0]   acc_step, prod_fix;
   logic [WIDTH:0]       trial;
   logic                 trial_ge;
   logic [WIDTH-1:0]     trial_diff;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // op[0]=0 selects the signed variants
   assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
   assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];

   assign acc_step = {acc_reg[2*WIDTH-2:0], 1'b0}
                   + (mag_b_reg[counter_reg] ? {{WIDTH{1'b0}}, mag_a_reg} : '0);
   assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;

   // Restoring step; the remainder stays below the divisor so only trial needs the extra bit
   assign trial      = {rem_reg, mag_a_reg[counter_reg]};
   assign trial_ge   = trial >= {1'b0, mag_b_reg};
   assign trial_diff = trial[WIDTH-1:0] - mag_b_reg;

   // A zero divisor leaves the dividend in the remainder; the quotient is forced to all ones
   assign quo_fix = dbz_reg ? '1 : (neg_res_reg ? -quo_reg : quo_reg);
   assign rem_fix = neg_rem_reg ? -rem_reg : rem_reg;

`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] prod_fast;
   // Sign-extended operands make the modulo-2^64 product correct for both signednesses
   assign prod_fast = {{WIDTH{a_neg}}, bus.a} * {{WIDTH{b_neg}}, bus.b};
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
`ifdef MULDIV_FAST_MULT_EN
               state_next = bus.op[1] ? RUN : WRITE;
`else
               state_next = RUN;
`endif
            end
         end
         RUN:     if (counter_reg == '0) state_next = FIX;
         FIX:     state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         counter_reg <= '0;
         is_div_reg  <= 1'b0;
         dbz_reg     <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         mag_a_reg   <= '0;
         mag_b_reg   <= '0;
         acc_reg     <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  is_div_reg  <= bus.op[1];
                  dbz_reg     <= bus.op[1] & (bus.b == '0);
                  neg_res_reg <= a_neg ^ b_neg;
                  neg_rem_reg <= a_neg;
                  mag_a_reg   <= a_neg ? -bus.a : bus.a;
                  mag_b_reg   <= b_neg ? -bus.b : bus.b;
                  counter_reg <= CNT_W'(WIDTH - 1);
                  acc_reg     <= '0;
                  rem_reg     <= '0;
                  quo_reg     <= '0;
`ifdef MULDIV_FAST_MULT_EN
                  if (!bus.op[1]) begin
                     hi_reg <= prod_fast[2*WIDTH-1:WIDTH];
                     lo_reg <= prod_fast[WIDTH-1:0];
                  end
`endif
               end
            end
            RUN: begin
               counter_reg <= counter_reg - CNT_W'(1);
               if (is_div_reg) begin
                  rem_reg <= trial_ge ? trial_diff : trial[WIDTH-1:0];
                  quo_reg <= {quo_reg[WIDTH-2:0], trial_ge};
               end else begin
                  acc_reg <= acc_step;
               end
            end
            FIX: begin
               if (is_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end else begin
                  hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state_reg != IDLE);
   assign bus.done        = (state_reg == WRITE);
   assign bus.hi_we       = {2{bus.done}};
   assign bus.lo_we       = {2{bus.done}};
   assign bus.div_by_zero = bus.done & dbz_reg;
   assign bus.hi          = hi_reg;
   assign bus.lo          = lo_reg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit that produces the 32-bit HI and LO results for MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI and LO holding registers. Each output has a 2-bit write enable that is 2'b11 for exactly one cycle when a result is ready, and 2'b00 otherwise. The pipeline stalls on busy while an operation is in flight.

Parameters:
WIDTH, 32, operand and result width. Only 32 is supported; any other value must fail a static assertion.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  32  rs operand (multiplicand / dividend); sampled with start
b  input  32  rt operand (multiplier / divisor); sampled with start
busy  output  1  high from the cycle after start is accepted until the end of the WRITE cycle
done  output  1  one-cycle pulse in the WRITE cycle
hi  output  32  result high: product[63:32] or remainder; valid while done=1
lo  output  32  result low: product[31:0] or quotient; valid while done=1
hi_we  output  2  2'b11 in the WRITE cycle, else 2'b00; drives the HI register enable
lo_we  output  2  2'b11 in the WRITE cycle, else 2'b00; drives the LO register enable
div_by_zero  output  1  pulses together with done when DIV/DIVU had b==0

Behaviour:
- Clocking and reset:
  - Everything is clocked on the rising edge of clk; reset is synchronous, active-high.
  - On reset: state=IDLE, busy=0, done=0, hi=0, lo=0, hi_we=2'b00, lo_we=2'b00, div_by_zero=0, counter=0.
- States: IDLE, RUN, FIX, WRITE.
- IDLE:
  - If start=1 in cycle T, latch op and the operand magnitudes. Signed ops take the absolute value of a and b; unsigned ops use them raw. Record the result signs.
  - Load counter=31 and go to RUN at T+1.
  - If start=0, stay in IDLE.
- RUN (cycles T+1..T+32): one iteration per cycle; counter decrements and the state leaves RUN after the iteration at counter==0.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract. One quotient bit per cycle; a 33-bit partial remainder handles unsigned 0xFFFFFFFF.
- FIX (T+33): apply sign correction.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negated if the signs differ (truncates toward zero); remainder takes the sign of the dividend.
  - Load the hi/lo output registers.
- WRITE (T+34):
  - done=1, hi_we=lo_we=2'b11, busy=1.
  - Next state is IDLE at T+35, where a new start can be accepted.
- Total latency: start at T gives done at T+34.
- Combinational outputs: done, hi_we, lo_we and div_by_zero are decoded from state and are 0 / 2'b00 outside WRITE.
- busy is 1 in RUN, FIX and WRITE.
- hi/lo hold their last written values between operations.
- Boundary conditions:
  - start while busy: ignored completely; the latched operands are not disturbed.
  - Divide by zero (either DIV or DIVU): full latency still applies; hi=a, lo=32'hFFFF_FFFF, div_by_zero=1 in WRITE.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (wraps, no trap).
  - Operand changes after the start cycle have no effect.
  - Reset mid-operation, in any state: the next edge returns to IDLE with all reset values; no write pulse is issued for the aborted operation.
  - reset and start in the same cycle: reset wins and the start is dropped.

Optional Feature:
MULDIV_FAST_MULT_EN
- Defined:
  - MULT/MULTU compute the 64-bit product with a single-cycle signed/unsigned multiply in the start cycle.
  - The FSM goes IDLE -> WRITE directly, so start at T gives done and write enables at T+1 and busy high only at T+1.
  - DIV/DIVU are unchanged at 34 cycles.
- Undefined: the iterative multiply described above is used, with 34-cycle latency.
- Results are bit-identical in both builds.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at T -> done and hi_we=lo_we=2'b11 at T+34 only; hi=0xFFFFFFFE, lo=0x00000001; busy high T+1..T+34.
2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0.
4. DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 with done at T+34. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
5. Start DIVU 100/7 at T; pulse start with MULTU 3*3 at T+5 -> the second request is ignored and the result is lo=14, hi=2. Start again and assert reset at T+10 -> busy=0 at T+11, no we pulse, hi/lo=0.
6. Build with MULDIV_FAST_MULT_EN: MULTU 0xFFFFFFFF*0xFFFFFFFF at T -> done at T+1 with the same values as scenario 1; a DIV issued afterwards still takes 34 cycles.
